// File: rtl/tdc_interval_meter.sv
// tdc_interval_meter: start/stop interval measurement from coarse count plus
// fine delay-line thermometer codes. Results are queued in a small FIFO and
// leave through a valid/ready handshake.
module tdc_interval_meter #(
  parameter int TAPS       = 64,
  parameter int TIMEOUT    = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_hit,
  input  logic            stop_hit,
  input  logic [7:0]      coarse,
  input  logic [TAPS-1:0] therm_start,
  input  logic [TAPS-1:0] therm_stop,
  output logic [16:0]     out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            timeout,
  output logic            overflow,
  output logic            busy
);
  localparam int FW = $clog2(TAPS) + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  // Bubble-tolerant fine conversion: count every set tap.
  function automatic logic [FW-1:0] popcnt(input logic [TAPS-1:0] v);
    logic [FW-1:0] c;
    c = '0;
    for (int i = 0; i < TAPS; i++) c = c + {{(FW-1){1'b0}}, v[i]};
    return c;
  endfunction

  logic          s1_start_q, s1_start_d, s1_stop_q, s1_stop_d;
  logic [7:0]    s1_coarse_q, s1_coarse_d;
  logic [FW-1:0] s1_fs_q, s1_fs_d, s1_fp_q, s1_fp_d;

  logic [0:0]    state_q, state_d;
  logic [7:0]    elapsed_q, elapsed_d, coarse_s_q, coarse_s_d;
  logic [FW-1:0] fine_s_q, fine_s_d;
  logic          meas, expire;
  logic [7:0]    ref_coarse, cdiff;
  logic [FW-1:0] ref_fine;
  logic [17:0]   prod, raw;
  logic          res_vld_q, res_vld_d;
  logic [16:0]   res_data_q, res_data_d;

  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          pop, full, wr_en;

  // Stage 1: capture hit flags, coarse count and converted fine codes.
  always_comb begin
    s1_start_d  = start_hit;
    s1_stop_d   = stop_hit;
    s1_coarse_d = coarse;
    s1_fs_d     = popcnt(therm_start);
    s1_fp_d     = popcnt(therm_stop);
  end

  // Arm/measure/timeout decisions; a stop always beats an expiry, a lone
  // start retriggers.
  always_comb begin
    state_d    = state_q;
    elapsed_d  = elapsed_q;
    coarse_s_d = coarse_s_q;
    fine_s_d   = fine_s_q;
    meas       = 1'b0;
    expire     = 1'b0;
    ref_coarse = coarse_s_q;
    ref_fine   = fine_s_q;
    case (state_q)
      IDLE: begin
        if (s1_start_q && s1_stop_q) begin
          meas       = 1'b1;
          ref_coarse = s1_coarse_q;
          ref_fine   = s1_fs_q;
        end else if (s1_start_q) begin
          state_d    = ARMED;
          coarse_s_d = s1_coarse_q;
          fine_s_d   = s1_fs_q;
          elapsed_d  = '0;
        end
      end
      default: begin
        elapsed_d = elapsed_q + 8'd1;
        if (s1_stop_q) begin
          meas    = 1'b1;
          state_d = s1_start_q ? ARMED : IDLE;
        end else if (!s1_start_q && elapsed_q == 8'(TIMEOUT)) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
        if (s1_start_q) begin
          coarse_s_d = s1_coarse_q;
          fine_s_d   = s1_fs_q;
          elapsed_d  = '0;
        end
      end
    endcase
  end

  // Interval arithmetic with clamp; raw[17] is the sign of the 18-bit result.
  always_comb begin
    cdiff     = s1_coarse_q - ref_coarse;
    prod      = {10'd0, cdiff} * 18'(TAPS);
    raw       = prod + 18'(ref_fine) - 18'(s1_fp_q);
    res_vld_d = meas;
    if (raw[17])      res_data_d = {1'b1, 16'h0000};
    else if (raw[16]) res_data_d = {1'b1, 16'hffff};
    else              res_data_d = {1'b0, raw[15:0]};
  end

  // FIFO bookkeeping; a pop in the same cycle makes room for a push when full.
  always_comb begin
    pop        = (count_q != '0) && out_ready;
    full       = (count_q == CW'(FIFO_DEPTH));
    wr_en      = res_vld_q && (!full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + AW'(1);
    count_d    = count_q + CW'(wr_en) - CW'(pop);
    overflow_d = overflow_q | (res_vld_q && full && !pop);
  end

  // State registers, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_start_q <= 1'b0;  s1_stop_q <= 1'b0;  s1_coarse_q <= '0;
      s1_fs_q    <= '0;    s1_fp_q   <= '0;
      state_q    <= IDLE;  elapsed_q <= '0;    coarse_s_q  <= '0;
      fine_s_q   <= '0;    res_vld_q <= 1'b0;  res_data_q  <= '0;
      wr_ptr_q   <= '0;    rd_ptr_q  <= '0;    count_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_start_q <= s1_start_d;  s1_stop_q <= s1_stop_d;  s1_coarse_q <= s1_coarse_d;
      s1_fs_q    <= s1_fs_d;     s1_fp_q   <= s1_fp_d;
      state_q    <= state_d;     elapsed_q <= elapsed_d;  coarse_s_q  <= coarse_s_d;
      fine_s_q   <= fine_s_d;    res_vld_q <= res_vld_d;  res_data_q  <= res_data_d;
      wr_ptr_q   <= wr_ptr_d;    rd_ptr_q  <= rd_ptr_d;   count_q     <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; empty slots are never observed, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= res_data_q;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 17'd0;
  assign timeout   = expire;
  assign overflow  = overflow_q;
  assign busy      = (state_q == ARMED);
endmodule

// File: tb/tb_tdc_interval_meter.sv
// Bench for tdc_interval_meter: directed vector table, hand-written corner
// sequences, then a randomized run against a timestamp-based reference model.
module tb_tdc_interval_meter;
  localparam int TAPS = 64;
  localparam int TMO  = 200;
  localparam int T    = 3000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_hit = 1'b0, stop_hit = 1'b0, out_ready = 1'b0;
  logic [7:0]      coarse = '0;
  logic [TAPS-1:0] therm_start = '0, therm_stop = '0;
  logic [16:0]     out_data;
  logic            out_valid, timeout, overflow, busy;

  int tests = 0;
  int fails = 0;

  tdc_interval_meter #(.TAPS(TAPS), .TIMEOUT(TMO), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start_hit(start_hit), .stop_hit(stop_hit),
    .coarse(coarse), .therm_start(therm_start), .therm_stop(therm_stop),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .timeout(timeout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          same;
    logic [7:0]  cs;
    int          fs;
    logic [7:0]  cp;
    int          fp;
    logic [16:0] exp;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [TAPS-1:0] th(input int n);
    logic [TAPS-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // One cycle of stimulus, applied at the falling edge.
  task automatic hit(input bit st, input bit sp, input logic [7:0] co,
                     input logic [TAPS-1:0] ts, input logic [TAPS-1:0] tp);
    @(negedge clk);
    start_hit = st; stop_hit = sp; coarse = co; therm_start = ts; therm_stop = tp;
  endtask

  task automatic idle1();
    hit(1'b0, 1'b0, 8'd0, '0, '0);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    hit(1'b1, v.same, v.cs, th(v.fs), v.same ? th(v.fp) : '0);
    if (!v.same) begin
      idle1(); idle1();
      hit(1'b0, 1'b1, v.cp, '0, th(v.fp));
    end
    idle1(); idle1();
    chk($sformatf("vec%0d_valid_early", idx), 32'(out_valid), 32'd0);
    idle1();
    chk($sformatf("vec%0d_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("vec%0d_data", idx), 32'(out_data), 32'(v.exp));
    idle1(); idle1();
  endtask

  // Reference: a measurement's value from the specification's formula.
  function automatic logic [16:0] mdl(input int cd, input int fs, input int fp);
    int r;
    r = cd * TAPS + fs - fp;
    if (r < 0)     return {1'b1, 16'h0000};
    if (r > 65535) return {1'b1, 16'hffff};
    return {1'b0, 16'(r)};
  endfunction

  logic        exp_v  [T+8];
  logic [16:0] exp_d  [T+8];
  logic        exp_to [T+8];
  logic        exp_b  [T+8];

  initial begin
    int first_k, npulse, seen;
    bit busy2, busy203, dense, armed, st, sp;
    int a_t, a_fs, fs, fp, n;
    logic [7:0] a_co, ccnt, co, cd;
    logic [TAPS-1:0] ts, tp;

    vecs[0] = '{1'b0, 8'd10,  40, 8'd13,  8, {1'b0, 16'd224}};
    vecs[1] = '{1'b0, 8'd250,  0, 8'd4,   0, {1'b0, 16'd640}};
    vecs[2] = '{1'b1, 8'd77,  20, 8'd77,  5, {1'b0, 16'd15}};
    vecs[3] = '{1'b1, 8'd3,    5, 8'd3,  20, {1'b1, 16'd0}};
    vecs[4] = '{1'b0, 8'd100,  0, 8'd100, 10, {1'b1, 16'd0}};
    vecs[5] = '{1'b0, 8'd0,   64, 8'd1,   0, {1'b0, 16'd128}};
    vecs[6] = '{1'b0, 8'd1,   64, 8'd0,   0, {1'b0, 16'd16384}};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    idle1(); idle1();

    for (int i = 0; i < 7; i++) run_vec(i);

    // Retrigger: the second start replaces the first
    hit(1'b1, 1'b0, 8'd5, '0, '0);
    idle1(); idle1();
    chk("retrig_busy", 32'(busy), 1);
    hit(1'b1, 1'b0, 8'd7, '0, '0);
    idle1(); idle1();
    hit(1'b0, 1'b1, 8'd9, '0, '0);
    idle1(); idle1(); idle1();
    chk("retrig_valid", 32'(out_valid), 1);
    chk("retrig_data", 32'(out_data), 32'd128);
    idle1(); idle1();

    // Timeout, then a lone stop that must be ignored
    first_k = -1; npulse = 0; busy2 = 0; busy203 = 1; seen = 0;
    hit(1'b1, 1'b0, 8'd20, th(3), '0);
    for (int k = 1; k <= 260; k++) begin
      idle1();
      if (timeout) begin
        npulse++;
        if (first_k < 0) first_k = k;
      end
      if (k == 2)   busy2 = busy;
      if (k == 203) busy203 = busy;
      if (out_valid) seen++;
    end
    chk("to_cycle", 32'(first_k), 32'(TMO + 2));
    chk("to_pulses", 32'(npulse), 1);
    chk("to_busy_rise", 32'(busy2), 1);
    chk("to_busy_fall", 32'(busy203), 0);
    chk("to_no_output", 32'(seen), 0);
    hit(1'b0, 1'b1, 8'd30, '0, th(2));
    for (int k = 0; k < 6; k++) begin
      idle1();
      if (out_valid || busy) seen++;
    end
    chk("lone_stop_ignored", 32'(seen), 0);

    // FIFO full: 5 measurements into 4 slots with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) hit(1'b1, 1'b1, 8'd0, th(10 + i), '0);
    repeat (6) idle1();
    chk("full_overflow", 32'(overflow), 1);
    chk("full_valid", 32'(out_valid), 1);
    for (int k = 0; k < 3; k++) chk("full_stall_data", 32'(out_data), 32'd10);
    for (int k = 0; k < 3; k++) begin
      idle1();
      chk("full_stable", 32'(out_data), 32'd10);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle1();
      chk("pop_valid", 32'(out_valid), 1);
      chk("pop_data", 32'(out_data), 32'(10 + i));
      out_ready = 1'b1;
    end
    idle1();
    chk("pop_empty", 32'(out_valid), 0);
    chk("overflow_sticky", 32'(overflow), 1);

    // Reset while armed with two words queued
    out_ready = 1'b0;
    hit(1'b1, 1'b1, 8'd0, th(3), '0);
    hit(1'b1, 1'b1, 8'd0, th(4), '0);
    hit(1'b1, 1'b0, 8'd50, '0, '0);
    idle1(); idle1(); idle1();
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_valid", 32'(out_valid), 1);
    idle1();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_timeout", 32'(timeout), 0);
    idle1();
    rst = 1'b0;
    out_ready = 1'b1;
    hit(1'b0, 1'b1, 8'd55, '0, th(1));
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      idle1();
      if (out_valid || busy) seen++;
    end
    chk("post_rst_stop", 32'(seen), 0);

    // Randomized run against the reference model, consumer always ready
    idle1();
    rst = 1'b1;
    idle1();
    rst = 1'b0;
    for (int i = 0; i < T + 8; i++) begin
      exp_v[i] = 1'b0; exp_d[i] = '0; exp_to[i] = 1'b0; exp_b[i] = 1'b0;
    end
    armed = 0; a_t = 0; a_fs = 0; a_co = '0; ccnt = '0; dense = 0;
    for (int t = 0; t < T; t++) begin
      @(negedge clk);
      chk("rnd_valid", 32'(out_valid), 32'(exp_v[t]));
      if (exp_v[t]) chk("rnd_data", 32'(out_data), 32'(exp_d[t]));
      chk("rnd_timeout", 32'(timeout), 32'(exp_to[t]));
      chk("rnd_busy", 32'(busy), 32'(exp_b[t]));

      if (t % 300 == 0) dense = bit'($urandom_range(0, 1));
      st = dense ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      sp = dense ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 399) == 0);
      ccnt = ccnt + 8'd1;
      co = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ccnt;
      n = $urandom_range(0, TAPS);
      ts = th(n);
      if ($urandom_range(0, 3) == 0) ts[$urandom_range(0, TAPS-1)] ^= 1'b1;
      n = $urandom_range(0, TAPS);
      tp = th(n);
      if ($urandom_range(0, 3) == 0) tp[$urandom_range(0, TAPS-1)] ^= 1'b1;
      start_hit = st; stop_hit = sp; coarse = co; therm_start = ts; therm_stop = tp;
      fs = $countones(ts);
      fp = $countones(tp);

      if (!armed) begin
        if (st && sp) begin
          exp_v[t+3] = 1'b1; exp_d[t+3] = mdl(0, fs, fp);
        end else if (st) begin
          armed = 1; a_t = t; a_co = co; a_fs = fs;
        end
      end else if (sp) begin
        cd = co - a_co;
        exp_v[t+3] = 1'b1; exp_d[t+3] = mdl(int'(cd), a_fs, fp);
        if (st) begin
          a_t = t; a_co = co; a_fs = fs;
        end else armed = 0;
      end else if (st) begin
        a_t = t; a_co = co; a_fs = fs;
      end else if (t == a_t + TMO + 1) begin
        exp_to[a_t + TMO + 2] = 1'b1;
        armed = 0;
      end
      exp_b[t+2] = armed;
    end
    idle1();
    chk("rnd_no_overflow", 32'(overflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tdc_interval_meter.md
# tdc_interval_meter

Measurement stage directly downstream of the coarse counter and the fine delay-line capture. On each start/stop hit pair it samples the 8-bit coarse count and the fine thermometer code, converts the thermometer to a bin count, and computes the start-to-stop interval in fine-bin units. Results go through a small FIFO with a valid/ready output handshake toward the readout logic.

## Interface
- `TAPS`, 64: fine delay-line taps per clock period. Power of two, 16..128.
- `TIMEOUT`, 200: maximum armed duration in clk cycles. Range 2..255.
- `FIFO_DEPTH`, 4: result FIFO entries. Power of two.
- `clk`  in  1  system clock, 200 MHz. Single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_hit`  in  1  single-cycle start event pulse, already synchronous to clk.
- `stop_hit`  in  1  single-cycle stop event pulse, already synchronous to clk.
- `coarse`  in  8  coarse counter value, sampled in the hit cycle.
- `therm_start`  in  TAPS  start delay-line snapshot, valid in the `start_hit` cycle.
- `therm_stop`  in  TAPS  stop delay-line snapshot, valid in the `stop_hit` cycle.
- `out_data`  out  17  {err, interval[15:0]}.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the word when `out_valid` and `out_ready` are both high.
- `timeout`  out  1  one-cycle pulse when an armed measurement expires.
- `overflow`  out  1  sticky. Set when a result is dropped on a full FIFO; cleared only by `rst`.
- `busy`  out  1  high while ARMED.

## Operation
- **Fine conversion:** fine = popcount of the snapshot, range 0..TAPS (bubble-tolerant). Stage 1 registers the fine value, `coarse`, and the hit flags.
- **FSM states:** IDLE and ARMED.
- **IDLE:**
  - Start only: store (coarse_s, fine_s), clear the elapsed counter, go to ARMED.
  - Start and stop in the same cycle: measure immediately with coarse_diff = 0, stay in IDLE.
  - Stop only: ignored.
- **ARMED:** the elapsed counter increments every cycle.
  - Stop only: compute and push the result, go to IDLE.
  - Start only: retrigger. Overwrite (coarse_s, fine_s), clear elapsed, stay in ARMED.
  - Stop and start together: complete the current measurement with the stop, then arm with the new start. Stay in ARMED, elapsed cleared.
  - elapsed == TIMEOUT with no stop: pulse `timeout`, push nothing, go to IDLE. A stop in that same cycle wins: the result is pushed and no timeout is raised.
- **Arithmetic:**
  - coarse_diff = (coarse_p − coarse_s) mod 256. This is valid because TIMEOUT < 256.
  - raw = coarse_diff·TAPS + fine_s − fine_p, computed in 18-bit signed.
  - raw < 0: interval = 0, err = 1.
  - raw > 65535: interval = 65535, err = 1.
  - Otherwise interval = raw, err = 0.
- **FIFO:**
  - Push and pop in the same cycle are allowed, including when full: the pop frees the slot and the push succeeds.
  - Push while full without a pop: word dropped, `overflow` set.
  - `out_data` is the head entry. It is held stable while `out_valid` is high and `out_ready` is low.
- **Reset mid-operation:** FSM returns to IDLE, FIFO is emptied, a pending start is discarded, `overflow` is cleared.

## Timing
- **Reset values:** `out_valid` = 0, `out_data` = 0, `timeout` = 0, `overflow` = 0, `busy` = 0.
- **Latency:**
  - Stop hit in cycle N: stage 1 registers in N+1, the FSM computes and pushes in N+2, `out_valid` is high at N+3 when the FIFO was empty.
  - `busy` rises 2 cycles after `start_hit`.
  - `timeout` pulses 2 + TIMEOUT cycles after the last start.
- **Throughput:** a hit is accepted every cycle. Back-to-back stop/start pairs are allowed.
- **Pop:** the head word is popped on a clk edge with `out_valid` and `out_ready` high. The next word is visible in the following cycle.

## Test plan
- **Basic interval:** start at coarse = 10 with 40 ones; stop at coarse = 13 with 8 ones (TAPS = 64) → `out_data` = {0, 224}, `out_valid` high 3 cycles after stop.
- **Coarse wrap-around:** start at coarse = 250, fine = 0; stop at coarse = 4, fine = 0 → interval = 640, err = 0.
- **Timeout and ignored stop:** start, then no stop for 200 cycles → one `timeout` pulse, `busy` falls, FIFO unchanged. A later lone stop produces no output.
- **Same-cycle and retrigger:**
  - Same-cycle start/stop in IDLE with fine 20/5 → interval = 15.
  - Start at coarse = 5, retrigger at coarse = 7, stop at coarse = 9 (all fine = 0) → interval = 128.
  - Same cycle with fine 5/20 → interval = 0, err = 1.
- **FIFO full:** `out_ready` = 0, 5 measurements → 4 stored, `overflow` = 1. Raise `out_ready` → 4 words pop in order, `out_data` stable while stalled.
- **Reset mid-operation:** assert `rst` while ARMED with 2 words queued → all outputs 0 immediately. A subsequent stop yields no output.
